load_align_unit: RTL and testbench

- Parametrised load-data aligner/extender for the MEM/WB path. Successor to the fixed 32-bit halfword extractor.
- Accepts a load request (address plus mode), issues one or two word-aligned data-memory reads, and extracts the byte, half, word or dword lane.
- Zero- or sign-extends the result to DATA_W, flags illegal or misaligned accesses, and returns the result over a valid/ready handshake.
- Sits between the MEM-stage load issue logic and the writeback mux.

---
 rtl/load_align_unit.sv | 163 ++++++++++++++++
 tb/tb_load_align_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load-data aligner/extender for the MEM/WB path: issues one or two word reads,
// extracts the byte/half/word/dword lane and zero- or sign-extends it.

module load_align_lane #(
    parameter int BYTES = 4,
    parameter int OFF_W = 2,
    parameter int LANE  = 0
) (
    input  logic [2*BYTES-1:0][7:0] merged,
    input  logic [OFF_W-1:0]        off,
    output logic [7:0]              lane_byte
);
    // Result byte LANE comes from merged byte off+LANE; the extra index bit reaches the high word.
    logic [OFF_W:0] idx;
    assign idx       = {1'b0, off} + (OFF_W + 1)'(LANE);
    assign lane_byte = merged[idx];
endmodule

module load_align_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter bit ALLOW_MISALIGN = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [2:0]        REQ_MODE,
    output logic              MEM_RD_EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, MERGE, RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        mode;
        logic              split;
    } req_t;

    state_t            state, state_nx;
    req_t              req_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    // Request decode, evaluated against the live inputs at accept time.
    int   off_i, sz_i;
    logic req_illegal, req_misal, req_split, req_err;

    always_comb begin
        off_i       = int'(REQ_ADDR[OFF_W-1:0]);
        sz_i        = 1 << REQ_MODE[1:0];
        req_illegal = (REQ_MODE == 3'b111) ||
                      (DATA_W == 32 && (REQ_MODE == 3'b011 || REQ_MODE == 3'b110));
        req_misal   = (off_i & (sz_i - 1)) != 0;
        req_split   = (off_i + sz_i) > BYTES;
        req_err     = req_illegal || (req_misal && !ALLOW_MISALIGN);
    end

    // Byte extraction from {hi, lo}; hi only matters for split accesses.
    logic [2*BYTES-1:0][7:0] merged;
    logic [BYTES-1:0][7:0]   field_b;
    logic [DATA_W-1:0]       field;

    always_comb begin
        merged = {{DATA_W{1'b0}}, MEM_RDATA};
        if (state == MERGE)
            merged = {MEM_RDATA, lo_q};
    end

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        load_align_lane #(.BYTES(BYTES), .OFF_W(OFF_W), .LANE(k)) u_lane (
            .merged   (merged),
            .off      (req_q.addr[OFF_W-1:0]),
            .lane_byte(field_b[k])
        );
    end

    assign field = field_b;

    // Shift the field to the top and back down to zero- or sign-fill.
    int                       sz_q, sh;
    logic [DATA_W-1:0]        lsh, result;
    logic signed [DATA_W-1:0] sres;

    always_comb begin
        sz_q   = 1 << req_q.mode[1:0];
        sh     = (8 * sz_q >= DATA_W) ? 0 : DATA_W - 8 * sz_q;
        lsh    = field << sh;
        sres   = $signed(lsh) >>> sh;
        result = req_q.mode[2] ? (lsh >> sh) : sres;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (REQ_VALID) state_nx = req_err ? RESP : RD_LO;
            RD_LO:   state_nx = RD_HI;
            RD_HI:   state_nx = req_q.split ? MERGE : RESP;
            MERGE:   state_nx = RESP;
            RESP:    if (RSP_READY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_q      <= '0;
            lo_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (REQ_VALID) begin
                    req_q      <= '{addr: REQ_ADDR, mode: REQ_MODE, split: req_split};
                    rsp_err_q  <= req_err;
                    rsp_data_q <= '0;
                end
                RD_HI: begin
                    lo_q <= MEM_RDATA;
                    if (!req_q.split) rsp_data_q <= result;
                end
                MERGE: rsp_data_q <= result;
                RESP: if (RSP_READY) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    logic [ADDR_W-1:0] aligned;
    assign aligned = {req_q.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        MEM_RD_EN = 1'b0;
        MEM_ADDR  = '0;
        if (state == RD_LO) begin
            MEM_RD_EN = 1'b1;
            MEM_ADDR  = aligned;
        end else if (state == RD_HI && req_q.split) begin
            MEM_RD_EN = 1'b1;
            MEM_ADDR  = aligned + ADDR_W'(BYTES);
        end
    end

    assign REQ_READY = (state == IDLE);
    assign RSP_VALID = (state == RESP);
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: dut 0 rejects misaligned loads, dut 1 services them.
module tb_load_align_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid[2], req_ready[2], mem_rd_en[2], rsp_valid[2], rsp_ready[2], rsp_err[2];
    logic [31:0] req_addr[2], mem_addr[2], mem_rdata[2], rsp_data[2];
    logic [2:0]  req_mode[2];
    logic [31:0] rd_log[2][64];
    int          rd_total[2] = '{0, 0};
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .REQ_ADDR(req_addr[0]), .REQ_MODE(req_mode[0]), .MEM_RD_EN(mem_rd_en[0]),
        .MEM_ADDR(mem_addr[0]), .MEM_RDATA(mem_rdata[0]), .RSP_VALID(rsp_valid[0]),
        .RSP_READY(rsp_ready[0]), .RSP_DATA(rsp_data[0]), .RSP_ERR(rsp_err[0]));

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .REQ_ADDR(req_addr[1]), .REQ_MODE(req_mode[1]), .MEM_RD_EN(mem_rd_en[1]),
        .MEM_ADDR(mem_addr[1]), .MEM_RDATA(mem_rdata[1]), .RSP_VALID(rsp_valid[1]),
        .RSP_READY(rsp_ready[1]), .RSP_DATA(rsp_data[1]), .RSP_ERR(rsp_err[1]));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hF1E2_D3C4;
            32'h0000_1004: return 32'h1122_3344;
            32'hFFFF_FFFC: return 32'hAABB_CCDD;
            32'h0000_0000: return 32'h5566_7788;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Synchronous memory: data valid the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_rd_en[i]) begin
                mem_rdata[i]                 <= mem_word(mem_addr[i]);
                rd_log[i][rd_total[i] & 63]  <= mem_addr[i];
                rd_total[i]                  <= rd_total[i] + 1;
            end else begin
                mem_rdata[i] <= 32'hDEAD_BEEF;
            end
        end
    end

    // Issue one load and wait for RSP_VALID; the response is left pending.
    task automatic do_load(input int d, input logic [31:0] a, input logic [2:0] m,
                           output logic [31:0] data, output logic err, output int lat,
                           output int nrd, output logic [31:0] a0, output logic [31:0] a1);
        int base;
        @(negedge clk);
        base         = rd_total[d];
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_mode[d]  = m;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = ~a;
        req_mode[d]  = 3'b111;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = rsp_data[d];
        err  = rsp_err[d];
        nrd  = rd_total[d] - base;
        a0   = rd_log[d][base & 63];
        a1   = rd_log[d][(base + 1) & 63];
    endtask

    task automatic finish_rsp(input int d);
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || mem_rd_en[d] !== 1'b0 ||
                mem_addr[d] !== 32'h0 || rsp_data[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut%0d got rdy=%b vld=%b rd=%b ma=%h data=%h err=%b exp rdy=1 rest 0",
                         d, req_ready[d], rsp_valid[d], mem_rd_en[d], mem_addr[d], rsp_data[d], rsp_err[d]);
            end
        end
    endtask

    task automatic test_aligned();
        logic [31:0] va[5] = '{32'h1002, 32'h1002, 32'h1001, 32'h1000, 32'h1000};
        logic [2:0]  vm[5] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b010};
        logic [31:0] ve[5] = '{32'hFFFF_F1E2, 32'h0000_F1E2, 32'hFFFF_FFD3, 32'h0000_00C4, 32'hF1E2_D3C4};
        logic [31:0] data, a0, a1;
        logic        err;
        int          lat, nrd;
        for (int i = 0; i < 5; i++) begin
            do_load(0, va[i], vm[i], data, err, lat, nrd, a0, a1);
            checks++;
            if (data !== ve[i] || err !== 1'b0) begin
                failures++;
                $display("FAIL aligned_data[%0d] got %h err=%b exp %h err=0", i, data, err, ve[i]);
            end
            checks++;
            if (lat !== 3 || nrd !== 1 || a0 !== 32'h1000) begin
                failures++;
                $display("FAIL aligned_timing[%0d] got lat=%0d reads=%0d addr=%h exp lat=3 reads=1 addr=00001000",
                         i, lat, nrd, a0);
            end
            finish_rsp(0);
        end
    endtask

    task automatic test_misalign_split();
        logic [31:0] data, a0, a1;
        logic        err;
        int          lat, nrd;
        do_load(1, 32'h1003, 3'b010, data, err, lat, nrd, a0, a1);
        checks++;
        if (data !== 32'h2233_44F1 || err !== 1'b0) begin
            failures++;
            $display("FAIL split_lw_data got %h err=%b exp 223344f1 err=0", data, err);
        end
        checks++;
        if (lat !== 4 || nrd !== 2 || a0 !== 32'h1000 || a1 !== 32'h1004) begin
            failures++;
            $display("FAIL split_lw_timing got lat=%0d reads=%0d a0=%h a1=%h exp 4 2 00001000 00001004",
                     lat, nrd, a0, a1);
        end
        finish_rsp(1);
        do_load(1, 32'h1001, 3'b001, data, err, lat, nrd, a0, a1);
        checks++;
        if (data !== 32'hFFFF_E2D3 || err !== 1'b0 || lat !== 3 || nrd !== 1) begin
            failures++;
            $display("FAIL misal_lh got %h err=%b lat=%0d reads=%0d exp ffffe2d3 0 3 1", data, err, lat, nrd);
        end
        finish_rsp(1);
    endtask

    task automatic test_error();
        logic [31:0] va[4] = '{32'h1003, 32'h1000, 32'h1000, 32'h1000};
        logic [2:0]  vm[4] = '{3'b010, 3'b011, 3'b111, 3'b110};
        int          vd[4] = '{0, 0, 0, 1};
        logic [31:0] data, a0, a1;
        logic        err;
        int          lat, nrd;
        for (int i = 0; i < 4; i++) begin
            do_load(vd[i], va[i], vm[i], data, err, lat, nrd, a0, a1);
            checks++;
            if (err !== 1'b1 || data !== 32'h0 || lat !== 1 || nrd !== 0) begin
                failures++;
                $display("FAIL error_path[%0d] got err=%b data=%h lat=%0d reads=%0d exp 1 00000000 1 0",
                         i, err, data, lat, nrd);
            end
            finish_rsp(vd[i]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] data, a0, a1;
        logic        err;
        int          lat, nrd;
        do_load(0, 32'h1000, 3'b010, data, err, lat, nrd, a0, a1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid[0] = 1'b1;
            req_addr[0]  = 32'h1002;
            req_mode[0]  = 3'b000;
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hF1E2_D3C4 || rsp_err[0] !== 1'b0 ||
                req_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got vld=%b data=%h err=%b rdy=%b exp 1 f1e2d3c4 0 0",
                         c, rsp_valid[0], rsp_data[0], rsp_err[0], req_ready[0]);
            end
        end
        req_valid[0] = 1'b0;
        finish_rsp(0);
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_data[0] !== 32'h0 || req_ready[0] !== 1'b1 || mem_rd_en[0] !== 1'b0) begin
            failures++;
            $display("FAIL after_handshake got vld=%b data=%h rdy=%b rd=%b exp 0 00000000 1 0",
                     rsp_valid[0], rsp_data[0], req_ready[0], mem_rd_en[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data, a0, a1;
        logic        err;
        int          lat, nrd;
        do_load(0, 32'h1002, 3'b101, data, err, lat, nrd, a0, a1);
        finish_rsp(0);
        do_load(0, 32'h1001, 3'b000, data, err, lat, nrd, a0, a1);
        checks++;
        if (data !== 32'hFFFF_FFD3 || lat !== 3) begin
            failures++;
            $display("FAIL back_to_back got %h lat=%0d exp ffffffd3 3", data, lat);
        end
        finish_rsp(0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h1003;
        req_mode[1]  = 3'b010;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_rd_en[1] !== 1'b1 || mem_addr[1] !== 32'h1004) begin
            failures++;
            $display("FAIL rd_hi_issue got rd=%b addr=%h exp 1 00001004", mem_rd_en[1], mem_addr[1]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_rd_en[1] !== 1'b0 || mem_addr[1] !== 32'h0 || rsp_valid[1] !== 1'b0 ||
            rsp_data[1] !== 32'h0 || rsp_err[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got rd=%b ma=%h vld=%b data=%h err=%b rdy=%b exp 0 0 0 0 0 1",
                     mem_rd_en[1], mem_addr[1], rsp_valid[1], rsp_data[1], rsp_err[1], req_ready[1]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0 || mem_rd_en[1] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL stale_after_reset got activity=%b exp 0", seen);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] data, a0, a1;
        logic        err;
        int          lat, nrd;
        do_load(1, 32'hFFFF_FFFE, 3'b010, data, err, lat, nrd, a0, a1);
        checks++;
        if (a0 !== 32'hFFFF_FFFC || a1 !== 32'h0 || nrd !== 2) begin
            failures++;
            $display("FAIL wrap_addr got a0=%h a1=%h reads=%0d exp fffffffc 00000000 2", a0, a1, nrd);
        end
        checks++;
        if (data !== 32'h7788_AABB || err !== 1'b0 || lat !== 4) begin
            failures++;
            $display("FAIL wrap_data got %h err=%b lat=%0d exp 7788aabb 0 4", data, err, lat);
        end
        finish_rsp(1);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            req_mode[d]  = '0;
            rsp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_aligned();
        test_misalign_split();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
